mem_rd_stage: RTL

Memory-read stage directly downstream of the MP pipeline latch. It takes a valid memory micro-op (physical address, request size, spill flag), and issues one or two line reads to the data cache. A spill (access crossing a 16-byte line) needs two reads. The stage extracts and zero-extends the requested bytes and presents a load result to the execute-side latch. It generates the stall that freezes the MP latch while a read is outstanding.

---
 rtl/mem_rd_pkg.sv | 17 +
 rtl/mem_byte_align.sv | 17 +
 rtl/mem_rd_stage.sv | 87 ++++++++
 3 files changed

// File: rtl/mem_rd_pkg.sv
// mem_rd_pkg: shared state encoding, request-size codes and line geometry for the memory-read stage.
package mem_rd_pkg;
  localparam int LINE_B = 16;
  localparam int OFF_W  = $clog2(LINE_B);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ1 = 2'd1,
    ST_REQ2 = 2'd2,
    ST_DONE = 2'd3
  } state_t;
  localparam logic [1:0] SZ_1B = 2'b00;
  localparam logic [1:0] SZ_2B = 2'b01;
  localparam logic [1:0] SZ_4B = 2'b10;
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    return sz == SZ_1B ? 3'd1 : sz == SZ_2B ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/mem_byte_align.sv
// mem_byte_align: selects n little-endian bytes at offset off from {lineB,lineA}, zero-extended to DW.
module mem_byte_align
  import mem_rd_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [16*LINE_B-1:0] i_lines,
  input  logic [OFF_W-1:0]     i_off,
  input  logic [2:0]           i_n,
  output logic [DW-1:0]        o_data
);
  logic [16*LINE_B-1:0] w_shift;
  logic [DW-1:0]        w_mask;
  assign w_shift = i_lines >> {i_off, 3'b000};
  assign w_mask  = i_n == 3'd1 ? DW'(8'hFF) : i_n == 3'd2 ? DW'(16'hFFFF) : DW'(32'hFFFF_FFFF);
  assign o_data  = w_shift[DW-1:0] & w_mask;
endmodule

// File: rtl/mem_rd_stage.sv
// mem_rd_stage: issues one or two line reads per load micro-op and returns the aligned,
// zero-extended result, stalling the upstream latch while a read is outstanding.
module mem_rd_stage
  import mem_rd_pkg::*;
#(
  parameter int PA_W = 15,
  parameter int DW   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_v,
  input  logic                i_mem_rd,
  input  logic [PA_W-1:0]     i_phys_addr,
  input  logic [1:0]          i_reqSize,
  input  logic                i_spill,
  input  logic                i_flush,
  input  logic                i_stall,
  output logic                o_stall,
  output logic                o_dc_req,
  output logic [PA_W-1:0]     o_dc_addr,
  input  logic                i_dc_ready,
  input  logic [8*LINE_B-1:0] i_dc_rdata,
  output logic                o_v,
  output logic [DW-1:0]       o_data
);
  state_t                r_state, w_next;
  logic [PA_W-1:0]       r_addr;
  logic [1:0]            r_size;
  logic                  r_spill;
  logic [8*LINE_B-1:0]   r_line_a;
  logic                  r_v;
  logic [DW-1:0]         r_data;
  logic                  w_acc, w_fin;
  logic [PA_W-1:0]       w_base;
  logic [16*LINE_B-1:0]  w_lines;
  logic [DW-1:0]         w_aligned;

  assign w_acc  = i_v & ~i_flush & (r_state == ST_IDLE | (r_state == ST_DONE & ~i_stall));
  assign w_fin  = ~i_flush & i_dc_ready & ((r_state == ST_REQ1 & ~r_spill) | r_state == ST_REQ2);
  assign w_base = {r_addr[PA_W-1:OFF_W], {OFF_W{1'b0}}};
  // The final line is aligned straight off the cache bus so the result registers on the last ready.
  assign w_lines = r_state == ST_REQ2 ? {i_dc_rdata, r_line_a} : {{(8*LINE_B){1'b0}}, i_dc_rdata};

  mem_byte_align #(.DW(DW)) u_align (
    .i_lines (w_lines),
    .i_off   (r_addr[OFF_W-1:0]),
    .i_n     (size_bytes(r_size)),
    .o_data  (w_aligned)
  );

  always_comb begin
    w_next = r_state;
    if (i_flush) w_next = ST_IDLE;
    else if (w_acc) w_next = i_mem_rd ? ST_REQ1 : ST_DONE;
    else if (r_state == ST_REQ1 & i_dc_ready) w_next = r_spill ? ST_REQ2 : ST_DONE;
    else if (r_state == ST_REQ2 & i_dc_ready) w_next = ST_DONE;
    else if (r_state == ST_DONE & ~i_stall) w_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_size   <= '0;
      r_spill  <= 1'b0;
      r_line_a <= '0;
      r_v      <= 1'b0;
      r_data   <= '0;
    end else begin
      r_state <= w_next;
      r_v     <= w_next == ST_DONE;
      if (w_acc) begin
        r_addr  <= i_phys_addr;
        r_size  <= i_reqSize;
        r_spill <= i_spill;
      end
      if (r_state == ST_REQ1 & i_dc_ready) r_line_a <= i_dc_rdata;
      if (w_acc & ~i_mem_rd) r_data <= '0;
      else if (w_fin) r_data <= w_aligned;
    end

  assign o_stall   = r_state == ST_REQ1 | r_state == ST_REQ2 | (r_state == ST_DONE & i_stall);
  assign o_dc_req  = r_state == ST_REQ1 | r_state == ST_REQ2;
  assign o_dc_addr = r_state == ST_REQ1 ? w_base : r_state == ST_REQ2 ? w_base + PA_W'(LINE_B) : '0;
  assign o_v       = r_v;
  assign o_data    = r_data;
endmodule
